// File: rtl/automorph_pkg.sv
// Shared constants and helpers for the automorph address path.
// Used by the sequencer and by the downstream AGU so both agree on widths.
package automorph_pkg;

  localparam int ADDR_WIDTH    = 10;
  localparam int MAX_R         = 31;
  localparam int R_WIDTH       = 5;
  localparam int IDX_WIDTH     = 32;
  localparam int WORDS_PER_ROT = 2 ** ADDR_WIDTH;

  // Sequencer FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_FIN   = 2'd3;

  // Limit a requested rotation count to MAX_R. Compared one bit wider so the
  // test stays meaningful if R_WIDTH is ever widened past MAX_R's range.
  function automatic logic [R_WIDTH-1:0] clamp_rot(input logic [R_WIDTH-1:0] n);
    logic [R_WIDTH:0] n_w;
    n_w = {1'b0, n};
    return (n_w > (R_WIDTH + 1)'(MAX_R)) ? R_WIDTH'(MAX_R) : n;
  endfunction

endpackage

// File: rtl/automorph_addr_sequencer_if.sv
// Tuple stream from the sequencer to the automorph AGU.
//   out_valid/out_ready   : handshake for the (i, input_address, r) tuple
//   out_last              : final tuple of the sweep
//   agu_valid/agu_last    : one-cycle-delayed qualifiers aligned with the
//                           AGU's registered output_address
interface automorph_addr_sequencer_if;
  import automorph_pkg::*;

  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_WIDTH-1:0]  i;
  logic [ADDR_WIDTH-1:0] input_address;
  logic [R_WIDTH-1:0]    r;
  logic                  out_last;
  logic                  agu_valid;
  logic                  agu_last;

  modport master (
    output out_valid, i, input_address, r, out_last, agu_valid, agu_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, i, input_address, r, out_last, agu_valid, agu_last,
    output out_ready
  );

endinterface

// File: rtl/automorph_sweep_counter.sv
// Nested word-address / rotation counter for one sweep.
//   clear     : restart at addr 0, r 0 (eff_rot must already hold the new count)
//   en        : advance by one word (one accepted tuple)
//   addr, r   : current position
//   addr_wrap : this advance rolls addr over into the next rotation
//   last      : registered; position is the final word of rotation eff_rot-1
module automorph_sweep_counter
  import automorph_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  en,
  input  logic [R_WIDTH-1:0]    eff_rot,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [R_WIDTH-1:0]    r,
  output logic                  addr_wrap,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(WORDS_PER_ROT - 1);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [R_WIDTH-1:0]    r_q, r_d;
  logic                  last_q, last_d;

  assign addr_wrap = en && (addr_q == ADDR_MAX);

  always_comb begin
    addr_d = addr_q;
    r_d    = r_q;
    if (clear) begin
      addr_d = '0;
      r_d    = '0;
    end else if (en) begin
      addr_d = addr_q + 1'b1;
      if (addr_q == ADDR_MAX) r_d = r_q + 1'b1;
    end
    // Computed from the next position so out_last is a flop, not a decode.
    last_d = (addr_d == ADDR_MAX) && (r_d == eff_rot - 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      r_q    <= '0;
      last_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      r_q    <= r_d;
      last_q <= last_d;
    end
  end

  assign addr = addr_q;
  assign r    = r_q;
  assign last = last_q;

endmodule

// File: rtl/automorph_addr_sequencer.sv
// Automorph address sequencer: sweeps every word of a slot block for each
// rotation of one FFT iteration and feeds (i, input_address, r) to the AGU.
//   clk, rst            : clock, async active-high reset
//   start/busy/done     : command interface from the DFT controller
//   num_rot, base_i,
//   i_stride            : sweep parameters, captured on an accepted start
//   bus (master)        : tuple stream + AGU qualifiers
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing tuples under valid/ready
// FLUSH | final tuple's qualifiers in flight
// FIN   | done pulse, busy released
module automorph_addr_sequencer
  import automorph_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [R_WIDTH-1:0]    num_rot,
  input  logic [IDX_WIDTH-1:0]  base_i,
  input  logic [IDX_WIDTH-1:0]  i_stride,
  output logic                  busy,
  output logic                  done,
  automorph_addr_sequencer_if.master bus
);

  state_t               state_q, state_d;
  logic [R_WIDTH-1:0]   eff_rot_q, eff_rot_d;
  logic [IDX_WIDTH-1:0] i_q, i_d;
  logic [IDX_WIDTH-1:0] stride_q, stride_d;
  logic                 out_valid_q, out_valid_d;
  logic                 agu_valid_q, agu_valid_d;
  logic                 agu_last_q, agu_last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                  xfer;
  logic                  cnt_clear;
  logic [R_WIDTH-1:0]    eff_req;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  logic [R_WIDTH-1:0]    cnt_r;
  logic                  cnt_wrap;
  logic                  cnt_last;

  assign xfer    = out_valid_q & bus.out_ready;
  assign eff_req = clamp_rot(num_rot);

  automorph_sweep_counter u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .en        (xfer),
    .eff_rot   (eff_rot_d),
    .addr      (cnt_addr),
    .r         (cnt_r),
    .addr_wrap (cnt_wrap),
    .last      (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    eff_rot_d   = eff_rot_q;
    i_d         = i_q;
    stride_d    = stride_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_clear   = 1'b0;
    agu_valid_d = xfer;
    agu_last_d  = xfer & cnt_last;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          eff_rot_d = eff_req;
          i_d       = base_i;
          stride_d  = i_stride;
          busy_d    = 1'b1;
          cnt_clear = 1'b1;
          // An empty sweep still spends one cycle in FLUSH so busy is seen
          // before done and start->done keeps the same tuples+3 shape.
          if (eff_req == '0) begin
            state_d = ST_FLUSH;
          end else begin
            state_d     = ST_RUN;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (cnt_wrap) i_d = i_q + stride_q;
          if (cnt_last) begin
            state_d     = ST_FLUSH;
            out_valid_d = 1'b0;
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_FIN;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      eff_rot_q   <= '0;
      i_q         <= '0;
      stride_q    <= '0;
      out_valid_q <= 1'b0;
      agu_valid_q <= 1'b0;
      agu_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      eff_rot_q   <= eff_rot_d;
      i_q         <= i_d;
      stride_q    <= stride_d;
      out_valid_q <= out_valid_d;
      agu_valid_q <= agu_valid_d;
      agu_last_q  <= agu_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.i             = i_q;
  assign bus.input_address = cnt_addr;
  assign bus.r             = cnt_r;
  assign bus.out_last      = cnt_last;
  assign bus.agu_valid     = agu_valid_q;
  assign bus.agu_last      = agu_last_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_automorph_addr_sequencer.sv
module tb_automorph_addr_sequencer;

  localparam int WORDS = 1024;
  localparam int MAXR  = 31;

  typedef struct packed {
    logic [31:0] i;
    logic [9:0]  a;
    logic [4:0]  r;
    logic        last;
  } tup_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  num_rot = '0;
  logic [31:0] base_i = '0;
  logic [31:0] i_stride = '0;
  logic        busy, done;

  automorph_addr_sequencer_if bus ();

  automorph_addr_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_rot  (num_rot),
    .base_i   (base_i),
    .i_stride (i_stride),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tup_t exp_q[$];
  int   xfer_cnt = 0, agu_cnt = 0, valid_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic prev_xfer = 1'b0, prev_last = 1'b0, held_v = 1'b0;
  tup_t held, cur;
  logic mx;

  logic        ready_mode = 1'b0;
  logic [15:0] rpat = 16'hB269;
  int          rpos = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // out_ready driver: always 1, or a fixed 50% pattern
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode) begin
        bus.out_ready = rpat[rpos];
        rpos = (rpos + 1) % 16;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_xfer = 1'b0;
        prev_last = 1'b0;
        held_v    = 1'b0;
      end else begin
        cur = {bus.i, bus.input_address, bus.r, bus.out_last};
        mx  = bus.out_valid & bus.out_ready;
        chk("agu_valid", bus.agu_valid, prev_xfer);
        chk("agu_last", bus.agu_last, prev_last);
        if (bus.agu_valid) agu_cnt++;
        if (bus.out_valid) valid_cnt++;
        if (held_v) begin
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_hold", cur, held);
        end
        if (mx) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tuple actual=%h expected=none", cur);
          end else begin
            chk("tuple", cur, exp_q.pop_front());
          end
          xfer_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        held_v    = bus.out_valid & ~bus.out_ready;
        held      = cur;
        prev_xfer = mx;
        prev_last = mx & bus.out_last;
      end
    end
  end

  task automatic push_sweep(input logic [4:0] n, input logic [31:0] bi, input logic [31:0] st);
    int eff;
    logic [31:0] iv;
    eff = int'(n);
    if (eff > MAXR) eff = MAXR;
    iv = bi;
    for (int rr = 0; rr < eff; rr++) begin
      for (int aa = 0; aa < WORDS; aa++)
        exp_q.push_back({iv, 10'(aa), 5'(rr), (rr == eff - 1) && (aa == WORDS - 1)});
      iv = iv + st;
    end
  endtask

  task automatic run_sweep(input string tag, input logic [4:0] n, input logic [31:0] bi,
                           input logic [31:0] st, input logic mode,
                           input logic busy_poke, input logic fin_poke);
    int eff, tuples, x0, a0, v0, d0, c0, budget;
    logic seen;
    eff = int'(n);
    if (eff > MAXR) eff = MAXR;
    tuples = eff * WORDS;
    push_sweep(n, bi, st);
    x0 = xfer_cnt; a0 = agu_cnt; v0 = valid_cnt; d0 = done_cnt;
    @(posedge clk);
    #1;
    ready_mode = mode;
    num_rot = n; base_i = bi; i_stride = st; start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_valid_after_start"}, bus.out_valid, eff > 0);
    budget = tuples * 4 + 50;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      #1;
      if (busy_poke && k == 300) begin
        start = 1'b1; num_rot = 5'd7; base_i = 32'hDEAD_0000; i_stride = 32'h1;
      end
      if (busy_poke && k == 301) start = 1'b0;
      if (done_cnt != d0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout actual=no_done required=done_within_%0d", tag, budget);
    end else begin
      // done is seen in the FIN cycle: edge count start->done = tuples+1,
      // i.e. tuples+3 cycles counting the start and done cycles themselves
      if (!mode) chk({tag, "_done_latency"}, done_cyc - c0, tuples + 1);
      chk({tag, "_busy_at_done"}, busy, 0);
      if (fin_poke) begin
        start = 1'b1; num_rot = 5'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_fin_start_busy"}, busy, 0);
        chk({tag, "_fin_start_valid"}, bus.out_valid, 0);
      end
    end
    repeat (2) @(negedge clk);
    #1;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_valid"}, bus.out_valid, 0);
    chk({tag, "_done_pulse_width"}, done, 0);
    chk({tag, "_xfer_count"}, xfer_cnt - x0, tuples);
    chk({tag, "_agu_count"}, agu_cnt - a0, tuples);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    if (eff == 0) chk({tag, "_no_valid"}, valid_cnt - v0, 0);
    exp_q.delete();
    ready_mode = 1'b0;
  endtask

  task automatic reset_abort();
    int x0, d0;
    logic got;
    push_sweep(5'd2, 32'h10, 32'h20);
    x0 = xfer_cnt; d0 = done_cnt;
    @(posedge clk);
    #1;
    num_rot = 5'd2; base_i = 32'h10; i_stride = 32'h20; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      #1;
      if (xfer_cnt - x0 >= 100) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rst_xfer_timeout actual=%0d required=100", xfer_cnt - x0);
    end
    #1;
    rst = 1'b1;
    #1;
    chk("rst_abort_outputs",
        {busy, done, bus.out_valid, bus.i, bus.input_address, bus.r, bus.out_last,
         bus.agu_valid, bus.agu_last}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_idle_busy", busy, 0);
  endtask

  initial begin
    #12;
    chk("init_reset_outputs",
        {busy, done, bus.out_valid, bus.i, bus.input_address, bus.r, bus.out_last,
         bus.agu_valid, bus.agu_last}, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_sweep("basic", 5'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    run_sweep("stall", 5'd2, 32'd3, 32'd5, 1'b1, 1'b0, 1'b1);
    run_sweep("zero",  5'd0, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0);
    run_sweep("max",   5'd31, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
    run_sweep("wrap",  5'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
    reset_abort();
    run_sweep("after_rst", 5'd1, 32'd5, 32'd2, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
